// File: rtl/fault_map_loader.sv
// Collects M activation beats into a vector next to a configurable per-lane fault map; start_reading pulses the cycle after the last beat.
// Config and activation beats are stalled (ready low) from that pulse until read_done; config wins over activation in IDLE.
module fault_map_loader #(
    parameter int N = 16,
    parameter int M = 16,
    localparam int LW = $clog2(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LW-1:0]       cfg_lane,
    input  logic                cfg_flip,
    input  logic                cfg_patch,
    input  logic [N-1:0]        cfg_value,
    input  logic                cfg_clear,
    input  logic                act_valid,
    output logic                act_ready,
    input  logic [N-1:0]        act_data,
    input  logic                read_done,
    output logic [M-1:0][N-1:0] activation_org,
    output logic [M-1:0][N-1:0] activation_cache,
    output logic [M-1:0]        f,
    output logic [M-1:0]        p,
    output logic                start_reading,
    output logic                busy,
    output logic                cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   lane_cnt;
    logic            cfg_fire;
    logic            clear_now;
    logic            act_fire;
    logic            last_lane;

    assign cfg_ready     = (state == IDLE);
    assign act_ready     = (state == FILL) || (state == IDLE && !cfg_valid && !cfg_clear);
    assign clear_now     = (state == IDLE) && cfg_clear;
    assign cfg_fire      = cfg_valid && cfg_ready && !cfg_clear;
    assign act_fire      = act_valid && act_ready;
    assign last_lane     = (lane_cnt == LW'(M - 1));
    assign start_reading = (state == ISSUE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (act_fire) state_nxt = FILL;
            FILL:    if (act_fire && last_lane) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    if (read_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fault map: clear outranks a same-cycle write; out-of-range lanes only raise the sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f                <= '0;
            p                <= '0;
            activation_cache <= '0;
            cfg_err          <= 1'b0;
        end else if (clear_now) begin
            f                <= '0;
            p                <= '0;
            activation_cache <= '0;
        end else if (cfg_fire) begin
            if (32'(cfg_lane) < M) begin
                f[cfg_lane]                <= cfg_flip;
                p[cfg_lane]                <= cfg_patch;
                activation_cache[cfg_lane] <= cfg_value;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // lane_cnt wraps explicitly at M-1 so non-power-of-two lane counts work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            activation_org <= '0;
            lane_cnt       <= '0;
        end else if (act_fire) begin
            activation_org[lane_cnt] <= act_data;
            lane_cnt                 <= last_lane ? '0 : lane_cnt + LW'(1);
        end
    end

endmodule

// File: tb/tb_fault_map_loader.sv
// Directed and randomized checks of fault_map_loader against a lane-level reference model (M=16), plus an M=12 instance for range errors.
module tb_fault_map_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // M=16 instance
    logic              cfg_valid, cfg_ready, cfg_flip, cfg_patch, cfg_clear;
    logic [3:0]        cfg_lane;
    logic [15:0]       cfg_value, act_data;
    logic              act_valid, act_ready, read_done;
    logic [15:0][15:0] activation_org, activation_cache;
    logic [15:0]       f, p;
    logic              start_reading, busy, cfg_err;

    // M=12 instance
    logic              b_cfg_valid, b_cfg_ready, b_cfg_flip, b_cfg_patch, b_cfg_clear;
    logic [3:0]        b_cfg_lane;
    logic [15:0]       b_cfg_value, b_act_data;
    logic              b_act_valid, b_act_ready, b_read_done;
    logic [11:0][15:0] b_org, b_cache;
    logic [11:0]       b_f, b_p;
    logic              b_start_reading, b_busy, b_cfg_err;

    fault_map_loader #(.N(16), .M(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_lane(cfg_lane),
        .cfg_flip(cfg_flip), .cfg_patch(cfg_patch), .cfg_value(cfg_value), .cfg_clear(cfg_clear),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .read_done(read_done),
        .activation_org(activation_org), .activation_cache(activation_cache), .f(f), .p(p),
        .start_reading(start_reading), .busy(busy), .cfg_err(cfg_err)
    );

    fault_map_loader #(.N(16), .M(12)) dut_b (
        .clk(clk), .reset(reset),
        .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_lane(b_cfg_lane),
        .cfg_flip(b_cfg_flip), .cfg_patch(b_cfg_patch), .cfg_value(b_cfg_value), .cfg_clear(b_cfg_clear),
        .act_valid(b_act_valid), .act_ready(b_act_ready), .act_data(b_act_data), .read_done(b_read_done),
        .activation_org(b_org), .activation_cache(b_cache), .f(b_f), .p(b_p),
        .start_reading(b_start_reading), .busy(b_busy), .cfg_err(b_cfg_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 vector just completed, 3 waiting for consumer.
    int          ph;
    int          cnt;
    logic [15:0] m_org   [16];
    logic [15:0] m_cache [16];
    logic [15:0] m_f, m_p;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ph = 0;
        cnt = 0;
        m_f = '0;
        m_p = '0;
        for (int i = 0; i < 16; i++) begin
            m_org[i] = '0;
            m_cache[i] = '0;
        end
    endtask

    task automatic check_outputs();
        logic [15:0][15:0] eo, ec;
        for (int i = 0; i < 16; i++) begin
            eo[i] = m_org[i];
            ec[i] = m_cache[i];
        end
        chk("activation_org", activation_org, eo);
        chk("activation_cache", activation_cache, ec);
        chk("f", f, m_f);
        chk("p", p, m_p);
        chk("start_reading", start_reading, ph == 2);
        chk("busy", busy, ph != 0);
        chk("cfg_err", cfg_err, 1'b0);
    endtask

    // One clock: check readies against the model, advance the model, then check registered outputs.
    task automatic tick();
        #1;
        chk("act_ready", act_ready, (ph == 1) || (ph == 0 && !cfg_valid && !cfg_clear));
        chk("cfg_ready", cfg_ready, ph == 0);
        case (ph)
            0: begin
                if (cfg_clear) begin
                    m_f = '0;
                    m_p = '0;
                    for (int i = 0; i < 16; i++) m_cache[i] = '0;
                end else if (cfg_valid) begin
                    m_f[cfg_lane] = cfg_flip;
                    m_p[cfg_lane] = cfg_patch;
                    m_cache[cfg_lane] = cfg_value;
                end else if (act_valid) begin
                    m_org[cnt] = act_data;
                    cnt++;
                    ph = 1;
                end
            end
            1: begin
                if (act_valid) begin
                    m_org[cnt] = act_data;
                    if (cnt == 15) begin
                        cnt = 0;
                        ph = 2;
                    end else begin
                        cnt++;
                    end
                end
            end
            2: ph = 3;
            default: if (read_done) ph = 0;
        endcase
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_lane = 0; cfg_flip = 0; cfg_patch = 0; cfg_value = 0; cfg_clear = 0;
        act_valid = 0; act_data = 0; read_done = 0;
        b_cfg_valid = 0; b_cfg_lane = 0; b_cfg_flip = 0; b_cfg_patch = 0; b_cfg_value = 0; b_cfg_clear = 0;
        b_act_valid = 0; b_act_data = 0; b_read_done = 0;
    endtask

    initial begin
        logic [15:0][15:0] snap_org;
        logic [11:0][15:0] b_exp;
        int issues;
        int cyc;

        // Reset values
        reset = 1;
        idle_inputs();
        model_reset();
        #3;
        check_outputs();
        chk("b_busy_reset", b_busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 0;

        // Asynchronous reset in the middle of a fill (lane 5 pending)
        act_valid = 1;
        for (int k = 0; k < 5; k++) begin
            act_data = 16'($urandom);
            tick();
        end
        chk("mid_fill_busy", busy, 1'b1);
        act_data = 16'hDEAD;
        reset = 1;
        #1;
        model_reset();
        check_outputs();
        act_valid = 0;
        #1;
        reset = 0;

        // Config write on lane 3, then a full fill starting from lane 0
        cfg_valid = 1; cfg_lane = 3; cfg_flip = 1; cfg_patch = 1; cfg_value = 16'hBEEF;
        tick();
        cfg_valid = 0;
        chk("f3", f[3], 1'b1);
        chk("p3", p[3], 1'b1);
        chk("cache3", activation_cache[3], 16'hBEEF);
        act_valid = 1;
        for (int k = 0; k < 16; k++) begin
            act_data = 16'h0100 + 16'(k);
            chk("no_early_start", start_reading, 1'b0);
            tick();
        end
        chk("start_pulse", start_reading, 1'b1);
        chk("lane0_data", activation_org[0], 16'h0100);
        chk("lane15_data", activation_org[15], 16'h010F);

        // Hold with both sources pushing: nothing accepted, outputs frozen
        snap_org = activation_org;
        cfg_valid = 1; cfg_lane = 9; cfg_value = 16'h1234;
        act_data = 16'hFFFF;
        for (int k = 0; k < 10; k++) tick();
        chk("hold_org_frozen", activation_org, snap_org);
        chk("hold_start_low", start_reading, 1'b0);
        cfg_valid = 0; act_valid = 0; read_done = 1;
        tick();
        read_done = 0;
        chk("back_to_idle", busy, 1'b0);

        // Clear, write and activation in the same IDLE cycle
        cfg_valid = 1; cfg_clear = 1; cfg_lane = 7; cfg_flip = 1; cfg_patch = 1; cfg_value = 16'hAAAA;
        act_valid = 1; act_data = 16'h5555;
        tick();
        idle_inputs();
        chk("clear_f", f, 16'h0);
        chk("clear_cache7", activation_cache[7], 16'h0);
        chk("no_act_taken", busy, 1'b0);

        // Out-of-range lane on the 12-lane instance
        b_cfg_valid = 1; b_cfg_lane = 15; b_cfg_flip = 1; b_cfg_patch = 1; b_cfg_value = 16'h7777;
        tick();
        b_cfg_valid = 0;
        chk("b_cfg_err", b_cfg_err, 1'b1);
        chk("b_f_untouched", b_f, 12'h0);
        chk("b_p_untouched", b_p, 12'h0);
        chk("b_cache_untouched", b_cache, 192'h0);
        b_act_valid = 1;
        for (int k = 0; k < 12; k++) begin
            b_act_data = 16'h0200 + 16'(k);
            b_exp[k] = b_act_data;
            chk("b_no_early_start", b_start_reading, 1'b0);
            tick();
        end
        b_act_valid = 0;
        chk("b_start", b_start_reading, 1'b1);
        chk("b_org", b_org, b_exp);
        chk("b_err_sticky", b_cfg_err, 1'b1);
        tick();
        b_read_done = 1;
        tick();
        b_read_done = 0;
        chk("b_idle", b_busy, 1'b0);
        chk("b_err_still", b_cfg_err, 1'b1);

        // Randomized traffic with gapped activations over three vectors
        issues = 0;
        cyc = 0;
        while (issues < 3 && cyc < 3000) begin
            cfg_valid = ($urandom % 8) == 0;
            cfg_lane  = 4'($urandom);
            cfg_flip  = 1'($urandom);
            cfg_patch = 1'($urandom);
            cfg_value = 16'($urandom);
            cfg_clear = ($urandom % 40) == 0;
            act_valid = 1'($urandom);
            act_data  = 16'($urandom);
            read_done = ($urandom % 4) == 0;
            tick();
            cyc++;
            if (ph == 2) issues++;
        end
        chk("random_vectors_issued", 32'(issues), 32'd3);

        idle_inputs();
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
